// File: rtl/rf_pkg.sv
// Shared register-file write-port types and widths.
package rf_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  wd;
  } rf_wr_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small FIFO holding LU results until a free register-file write slot appears.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  rf_wr_t din,
  output rf_wr_t head,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);

  rf_wr_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (!push && pop) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full)) else $error("rf_wr_fifo: push while full");
      assert (!(pop && empty)) else $error("rf_wr_fifo: pop while empty");
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB has fixed priority, queued LU results fill idle slots,
// with a starvation request and a busy scoreboard for outstanding LU destinations.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_wd,
  input  logic             lu_issue,
  input  logic [REG_W-1:0] lu_issue_rd,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [REG_W-1:0] lu_rd,
  input  logic [XLEN-1:0]  lu_wd,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_a3,
  output logic [XLEN-1:0]  rf_wd,
  input  logic [REG_W-1:0] q_rs1,
  input  logic [REG_W-1:0] q_rs2,
  input  logic [REG_W-1:0] q_rd,
  output logic             hazard,
  output logic             starve_req
);

  localparam int AW = $clog2(STARVE_MAX) + 1;

  rf_wr_t           lu_in;
  rf_wr_t           head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             wb_slot;
  logic [AW-1:0]    age;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // x0 writes are architecturally dead, so they leave the slot free for the FIFO.
  assign wb_slot  = wb_we && (wb_rd != '0);
  assign pop      = !rst && !wb_slot && !empty;
  assign lu_ready = rst || !full;
  assign push     = !rst && lu_valid && lu_ready && (lu_rd != '0);
  assign lu_in    = '{rd: lu_rd, wd: lu_wd};

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (lu_in),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (!rst) begin
      if (wb_slot) begin
        rf_we = 1'b1;
        rf_a3 = wb_rd;
        rf_wd = wb_wd;
      end else if (!empty) begin
        rf_we = 1'b1;
        rf_a3 = head.rd;
        rf_wd = head.wd;
      end
    end
  end

  // Saturates so a misbehaving upstream cannot wrap the age back below threshold.
  always_ff @(posedge clk) begin
    if (rst || pop || empty) age <= '0;
    else if (age != {AW{1'b1}}) age <= age + AW'(1);
  end

  assign starve_req = !rst && !empty && (age >= AW'(STARVE_MAX - 1));

  // Clear first so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[head.rd] = 1'b0;
    if (lu_issue && (lu_issue_rd != '0)) busy_nxt[lu_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign hazard = !rst && (busy[q_rs1] || busy[q_rs2] || busy[q_rd]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wb_slot && busy[wb_rd]))
        else $error("rf_wr_arbiter: WB write to register with outstanding LU result");
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios then randomized traffic against a queue-based model.
module tb_rf_wr_arbiter;
  import rf_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        hazard;
  logic        starve_req;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_wd       (wb_wd),
    .lu_issue    (lu_issue),
    .lu_issue_rd (lu_issue_rd),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_rd       (lu_rd),
    .lu_wd       (lu_wd),
    .rf_we       (rf_we),
    .rf_a3       (rf_a3),
    .rf_wd       (rf_wd),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .q_rd        (q_rd),
    .hazard      (hazard),
    .starve_req  (starve_req)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state: queued results in arrival order, busy set, cycles the head has waited.
  rf_wr_t mq[$];
  bit     mbusy[32];
  int     mwait;
  bit     starve_prev;
  bit     lu_taken;
  int     pending[$];

  task automatic idle();
    rst = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_wd = '0;
    lu_issue = 1'b0; lu_issue_rd = '0; lu_valid = 1'b0; lu_rd = '0; lu_wd = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
  endtask

  // Compare outputs for the current inputs, advance the model across the posedge.
  task automatic step();
    bit          wb_slot, pop, ready, e_we, e_haz, e_starve, was_empty;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    rf_wr_t      h;
    #1;
    wb_slot = wb_we && (wb_rd != 0);
    ready   = rst || (mq.size() < DEPTH);
    e_we = 0; e_a3 = '0; e_wd = '0; pop = 0;
    if (!rst) begin
      if (wb_slot) begin
        e_we = 1; e_a3 = wb_rd; e_wd = wb_wd;
      end else if (mq.size() > 0) begin
        pop = 1; e_we = 1; e_a3 = mq[0].rd; e_wd = mq[0].wd;
      end
    end
    e_haz    = !rst && (mbusy[q_rs1] || mbusy[q_rs2] || mbusy[q_rd]);
    e_starve = !rst && (mq.size() > 0) && (mwait >= STARVE_MAX - 1);
    chk_eq("rf_we",      32'(rf_we),      32'(e_we));
    chk_eq("rf_a3",      32'(rf_a3),      32'(e_a3));
    chk_eq("rf_wd",      rf_wd,           e_wd);
    chk_eq("lu_ready",   32'(lu_ready),   32'(ready));
    chk_eq("hazard",     32'(hazard),     32'(e_haz));
    chk_eq("starve_req", 32'(starve_req), 32'(e_starve));
    starve_prev = e_starve;
    lu_taken    = !rst && lu_valid && ready;
    if (rst) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 0;
      mwait = 0;
    end else begin
      was_empty = (mq.size() == 0);
      if (pop) begin
        h = mq.pop_front();
        mbusy[h.rd] = 0;
      end
      if (lu_valid && ready && lu_rd != 0) mq.push_back('{rd: lu_rd, wd: lu_wd});
      if (lu_issue && lu_issue_rd != 0) mbusy[lu_issue_rd] = 1;
      mwait = (pop || was_empty) ? 0 : mwait + 1;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd);
    idle(); lu_issue = 1'b1; lu_issue_rd = rd; step();
  endtask

  initial begin
    int r;
    bit in_pend;
    mwait = 0; starve_prev = 0; lu_taken = 0;
    foreach (mbusy[i]) mbusy[i] = 0;
    @(negedge clk);

    idle(); rst = 1'b1; step(); step();
    idle(); #1;
    chk_eq("reset_we", 32'(rf_we), 0);
    chk_eq("reset_ready", 32'(lu_ready), 1);
    step();

    // WB only
    idle(); wb_we = 1'b1; wb_rd = 5'd5; wb_wd = 32'h1234; #1;
    chk_eq("t1_we", 32'(rf_we), 1);
    chk_eq("t1_a3", 32'(rf_a3), 5);
    chk_eq("t1_wd", rf_wd, 32'h1234);
    step();

    // Idle drain
    issue(5'd7);
    idle(); q_rs1 = 5'd7; lu_valid = 1'b1; lu_rd = 5'd7; lu_wd = 32'hDEAD; #1;
    chk_eq("t2_hazard_set", 32'(hazard), 1);
    chk_eq("t2_no_bypass", 32'(rf_we), 0);
    step();
    idle(); q_rs1 = 5'd7; #1;
    chk_eq("t2_drain_a3", 32'(rf_a3), 7);
    chk_eq("t2_drain_wd", rf_wd, 32'hDEAD);
    step();
    idle(); q_rs1 = 5'd7; #1;
    chk_eq("t2_hazard_clr", 32'(hazard), 0);
    step();

    // Conflict and starvation
    issue(5'd3);
    idle(); wb_we = 1'b1; wb_rd = 5'd10; wb_wd = 32'h10; lu_valid = 1'b1; lu_rd = 5'd3; lu_wd = 32'h33;
    step();
    for (int i = 0; i < STARVE_MAX - 1; i++) begin
      idle(); wb_we = 1'b1; wb_rd = 5'd10; wb_wd = 32'(i); #1;
      chk_eq("t3_starve_low", 32'(starve_req), 0);
      step();
    end
    idle(); wb_we = 1'b1; wb_rd = 5'd10; wb_wd = 32'h77; #1;
    chk_eq("t3_starve_high", 32'(starve_req), 1);
    step();
    idle(); #1;
    chk_eq("t3_head_a3", 32'(rf_a3), 3);
    chk_eq("t3_head_wd", rf_wd, 32'h33);
    step();
    idle(); #1;
    chk_eq("t3_starve_fall", 32'(starve_req), 0);
    step();

    // Full FIFO backpressure
    issue(5'd12); issue(5'd13); issue(5'd14);
    idle(); wb_we = 1'b1; wb_rd = 5'd11; lu_valid = 1'b1; lu_rd = 5'd12; lu_wd = 32'hC; step();
    idle(); wb_we = 1'b1; wb_rd = 5'd11; lu_valid = 1'b1; lu_rd = 5'd13; lu_wd = 32'hD; step();
    idle(); wb_we = 1'b1; wb_rd = 5'd11; lu_valid = 1'b1; lu_rd = 5'd14; lu_wd = 32'hE; #1;
    chk_eq("t4_full", 32'(lu_ready), 0);
    step();
    idle(); lu_valid = 1'b1; lu_rd = 5'd14; lu_wd = 32'hE; #1;
    chk_eq("t4_pop_a3", 32'(rf_a3), 12);
    chk_eq("t4_still_full", 32'(lu_ready), 0);
    step();
    idle(); wb_we = 1'b1; wb_rd = 5'd11; lu_valid = 1'b1; lu_rd = 5'd14; lu_wd = 32'hE; #1;
    chk_eq("t4_ready_again", 32'(lu_ready), 1);
    step();

    // x0 handling
    idle(); wb_we = 1'b1; wb_rd = 5'd0; wb_wd = 32'hBAD; #1;
    chk_eq("t5_x0_we", 32'(rf_we), 1);
    chk_eq("t5_x0_a3", 32'(rf_a3), 13);
    step();
    idle(); wb_we = 1'b1; wb_rd = 5'd0; step();
    idle(); lu_valid = 1'b1; lu_rd = 5'd0; lu_wd = 32'h55; step();
    idle(); #1;
    chk_eq("t5_x0_dropped", 32'(rf_we), 0);
    step();

    // Reset mid-operation
    issue(5'd4); issue(5'd9);
    idle(); wb_we = 1'b1; wb_rd = 5'd11; lu_valid = 1'b1; lu_rd = 5'd4; lu_wd = 32'h4; step();
    idle(); wb_we = 1'b1; wb_rd = 5'd11; lu_valid = 1'b1; lu_rd = 5'd9; lu_wd = 32'h9; step();
    idle(); rst = 1'b1; q_rs1 = 5'd4; #1;
    chk_eq("t6_rst_we", 32'(rf_we), 0);
    chk_eq("t6_rst_hazard", 32'(hazard), 0);
    step();
    idle(); q_rs1 = 5'd4; q_rs2 = 5'd9; #1;
    chk_eq("t6_post_we", 32'(rf_we), 0);
    chk_eq("t6_post_hazard", 32'(hazard), 0);
    step();

    // Randomized legal traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst = ($urandom_range(0, 399) == 0);
      r = $urandom_range(1, 31);
      in_pend = 0;
      foreach (pending[k]) if (pending[k] == r) in_pend = 1;
      if (!mbusy[r] && !in_pend && $urandom_range(0, 2) == 0) begin
        lu_issue = 1'b1; lu_issue_rd = 5'(r);
      end
      if (!starve_prev && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 31);
        if (mbusy[r]) r = 0;
        wb_we = 1'b1; wb_rd = 5'(r); wb_wd = $urandom;
      end
      if (pending.size() > 0 && $urandom_range(0, 1) == 0) begin
        lu_valid = 1'b1; lu_rd = 5'(pending[0]); lu_wd = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        lu_valid = 1'b1; lu_rd = '0; lu_wd = $urandom;
      end
      q_rs1 = 5'($urandom_range(0, 31));
      q_rs2 = 5'($urandom_range(0, 31));
      q_rd  = 5'($urandom_range(0, 31));
      step();
      if (rst) pending.delete();
      else begin
        if (lu_taken && lu_rd != 0) void'(pending.pop_front());
        if (lu_issue) pending.push_back(int'(lu_issue_rd));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
